// File: rtl/cnn_pkg.sv
// Shared sizes, FSM state type, fixed weights and a signed max helper for the CNN core.
package cnn_pkg;

    localparam int DATA_W = 32;
    localparam int IMG_W  = 8;
    localparam int CONV_W = IMG_W - 2;
    localparam int POOL_W = CONV_W / 2;

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StPool,
        StFc,
        StDone
    } cnn_state_e;

    // Convolution kernel, row-major K[i][j] = KERNEL[i*3+j].
    localparam logic signed [DATA_W-1:0] KERNEL [0:8] = '{
        32'sd1, 32'sd1, 32'sd1,
        32'sd1, 32'sd1, 32'sd1,
        32'sd1, 32'sd1, 32'sd1
    };

    // Fully-connected weights, indexed by pooled position r*3+c.
    localparam logic signed [DATA_W-1:0] FC_W [0:8] = '{
        32'sd1, 32'sd1, 32'sd1,
        32'sd1, 32'sd1, 32'sd1,
        32'sd1, 32'sd1, 32'sd1
    };

    function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_conv3x3_mac.sv
// Combinational 3x3 signed dot product against the fixed kernel, followed by ReLU.
module cnn_conv3x3_mac
    import cnn_pkg::*;
(
    input  logic [DATA_W-1:0] taps_i [0:8],
    output logic [DATA_W-1:0] relu_o
);

    logic [DATA_W-1:0] sum;

    // Wrapping 32-bit sum of products; ReLU looks only at the wrapped sign bit.
    always_comb begin
        sum = '0;
        for (int k = 0; k < 9; k++) begin
            sum = sum + DATA_W'(KERNEL[k] * $signed(taps_i[k]));
        end
        relu_o = sum[DATA_W-1] ? '0 : sum;
    end

endmodule

// File: rtl/cnn_top.sv
// Single-image CNN core: snapshot image, 3x3 conv + ReLU, 2x2 max-pool, 9-input FC reduction.
module cnn_top
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] input_img [0:IMG_W*IMG_W-1],
    output logic [DATA_W-1:0] value,
    output logic              done
);

    cnn_state_e        state_q, state_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] img_q  [0:IMG_W*IMG_W-1];
    logic [DATA_W-1:0] img_d  [0:IMG_W*IMG_W-1];
    logic [DATA_W-1:0] fmap_q [0:CONV_W*CONV_W-1];
    logic [DATA_W-1:0] fmap_d [0:CONV_W*CONV_W-1];
    logic [DATA_W-1:0] pool_q [0:POOL_W*POOL_W-1];
    logic [DATA_W-1:0] pool_d [0:POOL_W*POOL_W-1];

    logic [DATA_W-1:0] taps [0:8];
    logic [DATA_W-1:0] conv_out;
    logic [DATA_W-1:0] pool_max;
    logic [DATA_W-1:0] fc_sum;
    logic [5:0]        conv_idx;
    logic [5:0]        pool_base;
    logic [3:0]        pool_idx;
    logic              last_col;
    logic              last_row;

    // Window gather, raster indices and per-stage datapath results for the current row/col.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                taps[i*3+j] = img_q[6'((int'(row_q) + i) * IMG_W + int'(col_q) + j)];
            end
        end
        conv_idx  = 6'(int'(row_q) * CONV_W + int'(col_q));
        pool_idx  = 4'(int'(row_q) * POOL_W + int'(col_q));
        pool_base = 6'(2 * int'(row_q) * CONV_W + 2 * int'(col_q));
        pool_max  = smax(smax(fmap_q[pool_base], fmap_q[pool_base + 6'd1]),
                         smax(fmap_q[pool_base + 6'(CONV_W)],
                              fmap_q[pool_base + 6'(CONV_W + 1)]));
        fc_sum    = acc_q + DATA_W'(FC_W[pool_idx] * $signed(pool_q[pool_idx]));
        if (state_q == StConv) begin
            last_col = (col_q == 3'(CONV_W - 1));
            last_row = (row_q == 3'(CONV_W - 1));
        end else begin
            last_col = (col_q == 3'(POOL_W - 1));
            last_row = (row_q == 3'(POOL_W - 1));
        end
    end

    cnn_conv3x3_mac u_mac (
        .taps_i (taps),
        .relu_o (conv_out)
    );

    // Next-state, counter stepping and register-file writes.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        acc_d   = acc_q;
        value_d = value_q;
        done_d  = done_q;
        img_d   = img_q;
        fmap_d  = fmap_q;
        pool_d  = pool_q;

        // Shared raster stepping; only meaningful in CONV/POOL/FC.
        if (state_q inside {StConv, StPool, StFc}) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? 3'd0 : row_q + 3'd1;
            end else begin
                col_d = col_q + 3'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                done_d = 1'b0;
                row_d  = '0;
                col_d  = '0;
                if (enable) begin
                    for (int k = 0; k < IMG_W * IMG_W; k++) begin
                        img_d[k] = input_img[k];
                    end
                    state_d = StConv;
                end
            end
            StConv: begin
                fmap_d[conv_idx] = conv_out;
                if (last_col && last_row) state_d = StPool;
            end
            StPool: begin
                pool_d[pool_idx] = pool_max;
                if (last_col && last_row) begin
                    acc_d   = '0;
                    state_d = StFc;
                end
            end
            StFc: begin
                acc_d = fc_sum;
                if (last_col && last_row) begin
                    value_d = fc_sum;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!enable) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state with synchronous reset; a reset mid-run abandons the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            acc_q   <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    // Data register files; contents are always rewritten before use, so no reset.
    always_ff @(posedge clk) begin
        img_q  <= img_d;
        fmap_q <= fmap_d;
        pool_q <= pool_d;
    end

    assign value = value_q;
    assign done  = done_q;

endmodule

// File: tb/tb_cnn_top.sv
// Scoreboard bench for cnn_top: expected scores queued at launch, compared when done rises.
module tb_cnn_top;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [31:0] img_drv [0:63];
    logic [31:0] value;
    logic        done;

    int          n_checks;
    int          n_errors;
    logic [31:0] sb_q [$];

    cnn_top u_dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .input_img (img_drv),
        .value     (value),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] v);
        for (int k = 0; k < 64; k++) img_drv[k] = v;
    endtask

    // Reference: valid 3x3 conv (all-ones kernel), ReLU, 2x2 max-pool, FC sum with unit weights.
    function automatic logic [31:0] model(input logic [31:0] im [0:63]);
        int fm [0:35];
        int pl [0:8];
        int s;
        int acc;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s = s + int'(im[(r + i) * 8 + c + j]);
                fm[r*6+c] = (s < 0) ? 0 : s;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s = fm[(2*r)*6 + 2*c];
                if (fm[(2*r)*6 + 2*c + 1] > s) s = fm[(2*r)*6 + 2*c + 1];
                if (fm[(2*r+1)*6 + 2*c] > s) s = fm[(2*r+1)*6 + 2*c];
                if (fm[(2*r+1)*6 + 2*c + 1] > s) s = fm[(2*r+1)*6 + 2*c + 1];
                pl[r*3+c] = s;
            end
        end
        acc = 0;
        for (int n = 0; n < 9; n++) acc = acc + pl[n];
        return 32'(acc);
    endfunction

    // Launch a run from IDLE, optionally release enable right after E0, and score the result.
    task automatic run_img(input string tag, input logic hold, input logic [31:0] spoil_en);
        int          lat;
        logic        got;
        logic [31:0] exp;
        sb_q.push_back(model(img_drv));
        enable = 1'b1;
        tick();                                   // E0
        if (!hold) enable = 1'b0;
        if (spoil_en != 32'd0) fill(32'h7777_7777);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 70 && !got; k++) begin
            tick();
            if (done) begin
                got = 1'b1;
                lat = k;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd54);
        exp = sb_q.pop_front();
        check({tag, "_value"}, value, exp);
        if (hold) begin
            tick();
            tick();
            check({tag, "_done_held"}, {31'd0, done}, 32'd1);
            check({tag, "_value_held"}, value, exp);
            enable = 1'b0;
        end
        tick();
        check({tag, "_done_clear"}, {31'd0, done}, 32'd0);
        check({tag, "_value_kept"}, value, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        fill(32'd1);
        tick();
        tick();
        rst = 1'b0;
        check("reset_value", value, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        // All ones: every conv = 9, pooled 9, score 81.
        fill(32'd1);
        run_img("ones", 1'b1, 32'd0);

        // All -1: conv -9 clipped by ReLU.
        fill(32'hFFFF_FFFF);
        run_img("neg", 1'b1, 32'd0);

        // Single hot corner pixels.
        fill(32'd0);
        img_drv[0] = 32'd5;
        run_img("px0", 1'b1, 32'd0);
        fill(32'd0);
        img_drv[63] = 32'd5;
        run_img("px63", 1'b1, 32'd0);

        // Wrapped sum goes negative; enable dropped right after E0 must not abort.
        fill(32'h1000_0000);
        run_img("wrap", 1'b0, 32'd0);

        // All twos, then input corrupted after E0.
        fill(32'd2);
        run_img("twos", 1'b1, 32'd1);

        // Reset on the 10th CONV cycle abandons the run and clears value.
        fill(32'd1);
        enable = 1'b1;
        tick();                                   // E0
        for (int k = 0; k < 9; k++) tick();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        enable = 1'b0;
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_value", value, 32'd0);
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done) check("abort_spurious_done", {31'd0, done}, 32'd0);
        end
        check("abort_idle_value", value, 32'd0);
        run_img("rerun", 1'b1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
